// File: rtl/cart_rom_server.sv
// Cartridge ROM responder: serves byte reads from a 16-bit memory port through a
// two-entry word buffer with LRU replacement and optional next-word prefetch.
module cart_rom_server #(
  parameter int unsigned ADDR_W   = 19,
  parameter bit          PREFETCH = 1'b1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr_bus,
  input  logic              rom_read,
  input  logic              flush,
  output logic [7:0]        rom_dout,
  output logic              rom_busy,
  output logic              mem_req,
  output logic [ADDR_W-2:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata
);
  localparam int unsigned WA_W = ADDR_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_DEMAND, S_PREFETCH} state_t;

  state_t          state, state_nxt;
  logic [1:0]      valid;
  logic [WA_W-1:0] tag [2];
  logic [15:0]     data [2];
  logic            lru, tgt, pf_pending, pf_tgt, discard;
  logic [WA_W-1:0] pf_addr;
  logic [WA_W-1:0] word_addr, next_word;
  logic [1:0]      hit;
  logic            hit_any, hit_idx, miss, other, keep, dup, pf_skip;

  // Buffer lookup and fill-side helper terms
  always_comb begin
    word_addr = addr_bus[ADDR_W-1:1];
    next_word = mem_addr + WA_W'(1);
    hit[0]    = valid[0] && (tag[0] == word_addr);
    hit[1]    = valid[1] && (tag[1] == word_addr);
    hit_any   = |hit;
    hit_idx   = hit[1];
    miss      = rom_read && !hit_any;
    other     = ~tgt;
    keep      = !flush && !discard;
    dup       = valid[other] && (tag[other] == mem_addr);
    pf_skip   = valid[other] && (tag[other] == next_word);
  end

  assign rom_dout = !hit_any    ? 8'hFF :
                    addr_bus[0] ? data[hit_idx][15:8] : data[hit_idx][7:0];
  assign rom_busy = reset_n && miss;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Demand misses win over a pending prefetch; a flush suppresses a new prefetch
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (miss)                       state_nxt = S_DEMAND;
        else if (pf_pending && !flush)  state_nxt = S_PREFETCH;
      end
      S_DEMAND, S_PREFETCH: begin
        if (mem_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    if (state == S_DEMAND || state == S_PREFETCH) mem_req = 1'b1;
  end

  // Request address, buffer fills, LRU and prefetch bookkeeping
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr   <= '0;
      valid      <= '0;
      tag        <= '{default: '0};
      data       <= '{default: '0};
      lru        <= 1'b0;
      tgt        <= 1'b0;
      pf_pending <= 1'b0;
      pf_addr    <= '0;
      pf_tgt     <= 1'b0;
      discard    <= 1'b0;
    end else begin
      if (rom_read && hit_any) lru <= ~hit_idx;
      case (state)
        S_IDLE: begin
          discard <= 1'b0;
          if (miss) begin
            mem_addr <= word_addr;
            tgt      <= lru;
            if (pf_pending && pf_addr == word_addr) pf_pending <= 1'b0;
          end else if (pf_pending && !flush) begin
            mem_addr <= pf_addr;
            tgt      <= pf_tgt;
          end
        end
        S_DEMAND: begin
          if (mem_ack) begin
            if (keep) begin
              valid[tgt] <= 1'b1;
              tag[tgt]   <= mem_addr;
              data[tgt]  <= mem_rdata;
              lru        <= other;
              if (dup) valid[other] <= 1'b0;
              if (PREFETCH && !pf_skip) begin
                pf_pending <= 1'b1;
                pf_addr    <= next_word;
                pf_tgt     <= other;
              end
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        S_PREFETCH: begin
          if (mem_ack) begin
            pf_pending <= 1'b0;
            if (keep) begin
              valid[tgt] <= 1'b1;
              tag[tgt]   <= mem_addr;
              data[tgt]  <= mem_rdata;
              if (dup) valid[other] <= 1'b0;
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        default: discard <= 1'b0;
      endcase
      // Flush overrides any fill landing on the same edge
      if (flush) begin
        valid      <= '0;
        pf_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cart_rom_server.sv
// Bench for cart_rom_server: directed scenarios plus randomized reads/acks checked
// against a two-slot buffer model driven by observed memory handshakes.
module tb_cart_rom_server;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned WA_W   = ADDR_W - 1;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] addr_bus;
  logic              rom_read;
  logic              flush;
  logic [7:0]        rom_dout;
  logic              rom_busy;
  logic              mem_req;
  logic [WA_W-1:0]   mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;

  cart_rom_server #(.ADDR_W(ADDR_W), .PREFETCH(1'b1)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .addr_bus (addr_bus),
    .rom_read (rom_read),
    .flush    (flush),
    .rom_dout (rom_dout),
    .rom_busy (rom_busy),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_lat  = 0;
  int wait_cnt = 0;
  bit spur_en  = 1'b0;
  bit rand_lat = 1'b0;
  logic [15:0] rom_ov [int];

  // Reference buffer: two slots of resident words plus replacement/prefetch intent
  bit              mv [2];
  logic [WA_W-1:0] mw [2];
  bit              mlru, pend, pf_slot, cur_slot, cur_dem, disc;
  logic [WA_W-1:0] pf_w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rom_word(input logic [WA_W-1:0] w);
    logic [31:0] t;
    if (rom_ov.exists(int'(w))) return rom_ov[int'(w)];
    t = {14'd0, w} * 32'd2654435761;
    return t[31:16];
  endfunction

  function automatic logic [7:0] rom_byte(input logic [ADDR_W-1:0] a);
    logic [15:0] d;
    d = rom_word(a[ADDR_W-1:1]);
    return a[0] ? d[15:8] : d[7:0];
  endfunction

  task automatic model_reset();
    mv = '{default: 1'b0};
    mw = '{default: '0};
    mlru = 1'b0; pend = 1'b0; pf_slot = 1'b0; cur_slot = 1'b0;
    cur_dem = 1'b0; disc = 1'b0; pf_w = '0; wait_cnt = 0;
  endtask

  // One clock cycle: drive inputs, check combinational outputs, then the handshake after the edge
  task automatic step(input logic rd, input logic [ADDR_W-1:0] a, input logic fl);
    logic            req_pre, ack, hit, h, o, nxt_req;
    logic [WA_W-1:0] maddr_pre, w, nxt_addr;
    req_pre   = mem_req;
    maddr_pre = mem_addr;
    ack       = 1'b0;
    if (req_pre) begin
      if (wait_cnt >= ack_lat) ack = 1'b1;
      else wait_cnt++;
    end else begin
      wait_cnt = 0;
      if (rand_lat) ack_lat = $urandom_range(0, 4);
      ack = spur_en && ($urandom_range(0, 9) == 0);
    end
    rom_read  = rd;
    addr_bus  = a;
    flush     = fl;
    mem_ack   = ack;
    mem_rdata = ack ? rom_word(maddr_pre) : 16'($urandom);
    #1;
    w   = a[ADDR_W-1:1];
    hit = 1'b0;
    h   = 1'b0;
    for (int i = 0; i < 2; i++)
      if (mv[i] && mw[i] == w) begin hit = 1'b1; h = 1'(i); end
    check("busy", 32'(rom_busy), 32'(rd && !hit));
    check("dout", 32'(rom_dout), hit ? 32'(rom_byte(a)) : 32'hFF);
    @(posedge clk_sys);
    #1;
    nxt_req  = req_pre;
    nxt_addr = maddr_pre;
    if (rd && hit) mlru = !h;
    if (req_pre && ack) begin
      nxt_req = 1'b0;
      if (!cur_dem) pend = 1'b0;
      if (!fl && !disc) begin
        o = !cur_slot;
        if (mv[o] && mw[o] == maddr_pre) mv[o] = 1'b0;
        mv[cur_slot] = 1'b1;
        mw[cur_slot] = maddr_pre;
        if (cur_dem) begin
          mlru = o;
          if (!(mv[o] && mw[o] == WA_W'(maddr_pre + 1'b1))) begin
            pend = 1'b1; pf_w = WA_W'(maddr_pre + 1'b1); pf_slot = o;
          end
        end
      end
    end else if (req_pre) begin
      if (fl) disc = 1'b1;
    end else begin
      disc = 1'b0;
      if (rd && !hit) begin
        nxt_req = 1'b1; nxt_addr = w; cur_dem = 1'b1; cur_slot = mlru;
        if (pend && pf_w == w) pend = 1'b0;
      end else if (pend && !fl) begin
        nxt_req = 1'b1; nxt_addr = pf_w; cur_dem = 1'b0; cur_slot = pf_slot;
      end
    end
    if (fl) begin
      mv   = '{default: 1'b0};
      pend = 1'b0;
    end
    check("mem_req", 32'(mem_req), 32'(nxt_req));
    if (nxt_req) check("mem_addr", 32'(mem_addr), 32'(nxt_addr));
  endtask

  function automatic logic [ADDR_W-1:0] pick_addr();
    logic [ADDR_W-1:0] off;
    off = ADDR_W'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0:       return off;
      1:       return 19'h7FFF8 + off;
      2:       return 19'h12340 + off;
      default: return ADDR_W'($urandom);
    endcase
  endfunction

  initial begin
    logic [ADDR_W-1:0] a;
    logic              rd;
    reset_n = 1'b0; addr_bus = '0; rom_read = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    rom_ov[int'(18'h3E000)] = 16'hA55A;
    rom_ov[int'(18'h3E001)] = 16'h1234;
    model_reset();
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    #1;
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_dout", 32'(rom_dout), 32'hFF);
    check("rst_busy", 32'(rom_busy), 32'h0);

    // Demand fill, then sequential prefetch of the next word
    ack_lat = 0;
    step(1'b1, 19'h7C000, 1'b0);
    check("t1_req", 32'(mem_req), 32'h1);
    check("t1_addr", 32'(mem_addr), 32'h3E000);
    step(1'b1, 19'h7C000, 1'b0);
    check("t1_dout", 32'(rom_dout), 32'h5A);
    check("t1_busy", 32'(rom_busy), 32'h0);
    step(1'b1, 19'h7C000, 1'b0);
    check("t2_pf_addr", 32'(mem_addr), 32'h3E001);
    step(1'b1, 19'h7C000, 1'b0);
    step(1'b1, 19'h7C003, 1'b0);
    check("t2_dout", 32'(rom_dout), 32'h12);
    check("t2_noreq", 32'(mem_req), 32'h0);

    // Prefetch wraps from the top word to word 0
    step(1'b1, 19'h7FFFE, 1'b0);
    step(1'b1, 19'h7FFFE, 1'b0);
    step(1'b1, 19'h7FFFE, 1'b0);
    check("t3_wrap", 32'(mem_addr), 32'h0);
    step(1'b1, 19'h7FFFE, 1'b0);
    step(1'b1, 19'h00000, 1'b0);
    check("t3_busy", 32'(rom_busy), 32'h0);
    check("t3_noreq", 32'(mem_req), 32'h0);

    // Demand miss raised while a slow prefetch is outstanding
    step(1'b1, 19'h12340, 1'b0);
    step(1'b1, 19'h12340, 1'b0);
    ack_lat = 5;
    step(1'b1, 19'h12340, 1'b0);
    check("t4_pf_addr", 32'(mem_addr), 32'h091A1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 19'h20000, 1'b0);
      check("t4_hold", 32'(mem_addr), 32'h091A1);
    end
    step(1'b1, 19'h20000, 1'b0);
    check("t4_gap", 32'(mem_req), 32'h0);
    addr_bus = 19'h12342;
    #1;
    check("t4_pf_busy", 32'(rom_busy), 32'h0);
    check("t4_pf_dout", 32'(rom_dout), 32'(rom_byte(19'h12342)));
    ack_lat = 0;
    step(1'b1, 19'h20000, 1'b0);
    check("t4_dem_addr", 32'(mem_addr), 32'h10000);
    step(1'b1, 19'h20000, 1'b0);

    // Flush coincident with the ack discards the fill
    ack_lat = 2;
    step(1'b1, 19'h40000, 1'b0);
    step(1'b1, 19'h40000, 1'b0);
    step(1'b1, 19'h40000, 1'b0);
    step(1'b1, 19'h40000, 1'b1);
    check("t5_req_drop", 32'(mem_req), 32'h0);
    check("t5_busy", 32'(rom_busy), 32'h1);
    step(1'b1, 19'h40000, 1'b0);
    check("t5_remiss", 32'(mem_addr), 32'h20000);
    repeat (4) step(1'b1, 19'h40000, 1'b0);

    // Asynchronous reset in mid-transaction; a late ack must be ignored
    ack_lat = 3;
    step(1'b1, 19'h50000, 1'b0);
    step(1'b1, 19'h50000, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check("t6_req", 32'(mem_req), 32'h0);
    check("t6_dout", 32'(rom_dout), 32'hFF);
    check("t6_busy", 32'(rom_busy), 32'h0);
    mem_ack = 1'b1;
    @(posedge clk_sys);
    #1 reset_n = 1'b1;
    rom_read = 1'b0;
    model_reset();
    @(posedge clk_sys);
    #1 mem_ack = 1'b0;
    check("t6_late_ack", 32'(mem_req), 32'h0);
    step(1'b1, 19'h50000, 1'b0);
    check("t6_reissue", 32'(mem_addr), 32'h28000);

    // Randomized traffic against the reference buffer
    rand_lat = 1'b1;
    spur_en  = 1'b1;
    a = pick_addr();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) a = pick_addr();
      rd = ($urandom_range(0, 9) != 0);
      step(rd, a, 1'($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
